// File: rtl/ahblite_gcd_pkg.sv
// ahblite_gcd_pkg
// Shared definitions for the AHB-Lite GCD engine: register word offsets
// (HADDR[4:2]), CTRL/STATUS bit positions and the engine state encoding.
package ahblite_gcd_pkg;

  // Word offsets, HADDR[4:2]
  localparam logic [2:0] OFF_A      = 3'd0;
  localparam logic [2:0] OFF_B      = 3'd1;
  localparam logic [2:0] OFF_CTRL   = 3'd2;
  localparam logic [2:0] OFF_STATUS = 3'd3;
  localparam logic [2:0] OFF_RESULT = 3'd4;

  // CTRL bits
  localparam int CTRL_START  = 0;
  localparam int CTRL_IRQ_EN = 1;
  localparam int CTRL_FLUSH  = 2;

  // STATUS bits
  localparam int STAT_BUSY  = 0;
  localparam int STAT_DONE  = 1;
  localparam int STAT_OVF   = 2;
  localparam int STAT_ERR   = 3;
  localparam int STAT_EMPTY = 4;
  localparam int STAT_FULL  = 5;
  localparam int STAT_CNT_LO = 8;
  localparam int STAT_CNT_HI = 12;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CALC = 2'd2,
    ST_PUSH = 2'd3
  } gcd_state_e;

endpackage

// File: rtl/gcd_iter_core.sv
// gcd_iter_core
// Subtract-based Euclid engine.
//   clk, rst_n      : clock, async active-low reset
//   i_start         : start request, honoured only in IDLE
//   i_a, i_b        : operands, sampled in LOAD
//   o_res, o_valid  : result, valid for the single PUSH cycle
//   o_busy          : high whenever the FSM is not IDLE
module gcd_iter_core
  import ahblite_gcd_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_res,
  output logic             o_valid,
  output logic             o_busy
);

  gcd_state_e       r_state, w_nxt;
  logic [WIDTH-1:0] r_a, r_b, r_res;
  logic             w_zero_op;

  assign w_zero_op = (i_a == '0) || (i_b == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_nxt;
  end

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      ST_IDLE: if (i_start) w_nxt = ST_LOAD;
      ST_LOAD: w_nxt = w_zero_op ? ST_PUSH : ST_CALC;
      ST_CALC: if (r_a == r_b) w_nxt = ST_PUSH;
      ST_PUSH: w_nxt = ST_IDLE;
      default: w_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a   <= '0;
      r_b   <= '0;
      r_res <= '0;
    end else begin
      case (r_state)
        ST_LOAD: begin
          r_a   <= i_a;
          r_b   <= i_b;
          // With one operand zero the OR is the other operand (0 for 0,0)
          r_res <= i_a | i_b;
        end
        ST_CALC: begin
          if (r_a > r_b)      r_a   <= r_a - r_b;
          else if (r_b > r_a) r_b   <= r_b - r_a;
          else                r_res <= r_a;
        end
        default: ;
      endcase
    end
  end

  assign o_res   = r_res;
  assign o_valid = (r_state == ST_PUSH);
  assign o_busy  = (r_state != ST_IDLE);

endmodule

// File: rtl/ahblite_gcd_engine.sv
// ahblite_gcd_engine
// AHB-Lite slave wrapping gcd_iter_core with operand registers, a pop-on-read
// result FIFO, sticky DONE/OVF/ERR flags and an optional level interrupt.
// Optional feature macro: GCD_IRQ_EN (CTRL.IRQ_EN and IRQ output); when not
// defined IRQ is tied low and CTRL bit1 reads 0.
//   HCLK, HRESETn         : clock, async active-low reset
//   HSEL..HREADY          : AHB-Lite slave inputs
//   HREADYOUT, HRESP      : constant OKAY / zero wait
//   HRDATA                : read data, zero-extended above WIDTH
//   IRQ                   : level interrupt
module ahblite_gcd_engine
  import ahblite_gcd_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic [2:0]  HSIZE,
  input  logic [3:0]  HPROT,
  input  logic        HWRITE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic [31:0] HRDATA,
  output logic        HRESP,
  output logic        IRQ
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  // Bus address phase
  logic       r_act, r_wr;
  logic [2:0] r_off;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_act <= 1'b0;
      r_wr  <= 1'b0;
      r_off <= '0;
    end else begin
      r_act <= HSEL & HTRANS[1] & HREADY;
      r_wr  <= HWRITE;
      r_off <= HADDR[4:2];
    end
  end

  logic w_wr_ev, w_rd_ev;
  assign w_wr_ev = r_act & r_wr;
  assign w_rd_ev = r_act & ~r_wr;

  // Operand registers
  logic [WIDTH-1:0] r_a, r_b;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_a <= '0;
      r_b <= '0;
    end else if (w_wr_ev) begin
      if (r_off == OFF_A) r_a <= HWDATA[WIDTH-1:0];
      if (r_off == OFF_B) r_b <= HWDATA[WIDTH-1:0];
    end
  end

  // Control decode
  logic w_ctrl_wr, w_stat_wr, w_start_req, w_start, w_flush;
  logic w_busy, w_valid;
  logic [WIDTH-1:0] w_res;

  assign w_ctrl_wr   = w_wr_ev && (r_off == OFF_CTRL);
  assign w_stat_wr   = w_wr_ev && (r_off == OFF_STATUS);
  assign w_start_req = w_ctrl_wr & HWDATA[CTRL_START];
  assign w_start     = w_start_req & ~w_busy;
  assign w_flush     = w_ctrl_wr & HWDATA[CTRL_FLUSH];

  gcd_iter_core #(.WIDTH(WIDTH)) u_core (
    .clk     (HCLK),
    .rst_n   (HRESETn),
    .i_start (w_start),
    .i_a     (r_a),
    .i_b     (r_b),
    .o_res   (w_res),
    .o_valid (w_valid),
    .o_busy  (w_busy)
  );

  // Result FIFO
  logic [WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [PW-1:0]    r_wp, r_rp;
  logic [CW-1:0]    r_cnt;
  logic             w_empty, w_full, w_push, w_pop;

  assign w_empty = (r_cnt == '0);
  assign w_full  = (r_cnt == CW'(FIFO_DEPTH));
  // A full FIFO drops the incoming result even if a pop lands the same cycle
  assign w_push  = w_valid & ~w_full;
  assign w_pop   = w_rd_ev && (r_off == OFF_RESULT) && !w_empty;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
    end else if (w_flush) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wp] <= w_res;
        r_wp        <= r_wp + 1'b1;
      end
      if (w_pop) r_rp <= r_rp + 1'b1;
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
    end
  end

  // Sticky flags; a set in the same cycle as a clear wins
  logic r_done, r_ovf, r_err;
  logic [31:0] w_clr;
  assign w_clr = w_stat_wr ? HWDATA : 32'd0;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_done <= 1'b0;
      r_ovf  <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_done <= (r_done & ~w_clr[STAT_DONE]) | w_valid;
      r_ovf  <= (r_ovf  & ~w_clr[STAT_OVF])  | (w_valid & w_full);
      r_err  <= (r_err  & ~w_clr[STAT_ERR])  | (w_start_req & w_busy);
    end
  end

  // Interrupt
  logic w_irq_en;
`ifdef GCD_IRQ_EN
  logic r_irq_en;
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)       r_irq_en <= 1'b0;
    else if (w_ctrl_wr) r_irq_en <= HWDATA[CTRL_IRQ_EN];
  end
  assign w_irq_en = r_irq_en;
  assign IRQ      = r_irq_en & (r_done | r_ovf | r_err);
`else
  assign w_irq_en = 1'b0;
  assign IRQ      = 1'b0;
`endif

  // Read mux, combinational off the registered offset
  logic [31:0] w_stat, w_rdata;

  always_comb begin
    w_stat = '0;
    w_stat[STAT_BUSY]  = w_busy;
    w_stat[STAT_DONE]  = r_done;
    w_stat[STAT_OVF]   = r_ovf;
    w_stat[STAT_ERR]   = r_err;
    w_stat[STAT_EMPTY] = w_empty;
    w_stat[STAT_FULL]  = w_full;
    w_stat[STAT_CNT_HI:STAT_CNT_LO] = 5'(r_cnt);
  end

  always_comb begin
    w_rdata = '0;
    if (w_rd_ev) begin
      case (r_off)
        OFF_A:      w_rdata = 32'(r_a);
        OFF_B:      w_rdata = 32'(r_b);
        OFF_CTRL:   w_rdata[CTRL_IRQ_EN] = w_irq_en;
        OFF_STATUS: w_rdata = w_stat;
        OFF_RESULT: w_rdata = w_empty ? 32'd0 : 32'(r_mem[r_rp]);
        default:    w_rdata = '0;
      endcase
    end
  end

  assign HRDATA    = w_rdata;
  assign HREADYOUT = 1'b1;
  assign HRESP     = 1'b0;

  logic w_unused;
  assign w_unused = &{1'b0, HSIZE, HPROT, HADDR[31:5], HADDR[1:0], HTRANS[0], HWDATA};

endmodule

// File: tb/tb_ahblite_gcd_engine.sv
module tb_ahblite_gcd_engine;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic        HSEL = 1'b0;
  logic [31:0] HADDR = '0;
  logic [1:0]  HTRANS = '0;
  logic [2:0]  HSIZE = 3'd2;
  logic [3:0]  HPROT = 4'h3;
  logic        HWRITE = 1'b0;
  logic [31:0] HWDATA = '0;
  logic        HREADY = 1'b1;
  logic        HREADYOUT, HRESP, IRQ;
  logic [31:0] HRDATA;

  int n_chk = 0;
  int n_fail = 0;

  localparam logic [31:0] A_A = 32'h00, A_B = 32'h04, A_CTRL = 32'h08,
                          A_STAT = 32'h0C, A_RES = 32'h10, A_UNM = 32'h14;

`ifdef GCD_IRQ_EN
  localparam logic IRQ_ON = 1'b1;
  localparam logic [31:0] CTRL_RB = 32'h2;
`else
  localparam logic IRQ_ON = 1'b0;
  localparam logic [31:0] CTRL_RB = 32'h0;
`endif

  ahblite_gcd_engine #(.WIDTH(32), .FIFO_DEPTH(4)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR),
    .HTRANS(HTRANS), .HSIZE(HSIZE), .HPROT(HPROT), .HWRITE(HWRITE),
    .HWDATA(HWDATA), .HREADY(HREADY), .HREADYOUT(HREADYOUT),
    .HRDATA(HRDATA), .HRESP(HRESP), .IRQ(IRQ)
  );

  always #5 HCLK = ~HCLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Every bus task is entered and left 1 time unit after a rising edge.
  // Writes return inside their data phase; reads return inside theirs with
  // the data sampled, so consecutive calls pipeline one transfer per cycle.
  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    HSEL = 1'b1; HTRANS = 2'b10; HADDR = addr; HWRITE = 1'b1;
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = data;
  endtask

  task automatic rd(input logic [31:0] addr, output logic [31:0] data);
    HSEL = 1'b1; HTRANS = 2'b10; HADDR = addr; HWRITE = 1'b0;
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00;
    data = HRDATA;
  endtask

  task automatic rdchk(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    rd(addr, d);
    chk(tag, d, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge HCLK); #1; end
  endtask

  task automatic gcd_run(input logic [31:0] a, input logic [31:0] b);
    wr(A_A, a); wr(A_B, b); wr(A_CTRL, 32'h1); idle(24);
  endtask

  initial begin
    idle(3);
    HRESETn = 1'b1;
    idle(1);

    // Reset state
    chk("rst_hreadyout", {31'd0, HREADYOUT}, 32'd1);
    chk("rst_hresp", {31'd0, HRESP}, 32'd0);
    chk("rst_irq", {31'd0, IRQ}, 32'd0);
    chk("rst_hrdata_idle", HRDATA, 32'd0);
    rdchk("rst_status", A_STAT, 32'h10);
    rdchk("rst_a", A_A, 32'd0);
    rdchk("rst_ctrl", A_CTRL, 32'd0);
    rdchk("rst_result", A_RES, 32'd0);
    idle(1);

    // gcd(12,8) = 4, k=2: busy N+1..N+5, done N+6
    wr(A_A, 12); wr(A_B, 8);
    rdchk("rd_a", A_A, 12);
    wr(A_CTRL, 32'h1);
    for (int i = 1; i <= 6; i++)
      rdchk($sformatf("g12_8_stat_n%0d", i), A_STAT, (i < 6) ? 32'h11 : 32'h102);
    rdchk("g12_8_res", A_RES, 4);
    rdchk("g12_8_res_empty", A_RES, 0);
    rdchk("g12_8_stat_after", A_STAT, 32'h12);
    wr(A_STAT, 32'h2);
    rdchk("done_w1c", A_STAT, 32'h10);

    // gcd(0,35): PUSH at N+2, result readable at N+3
    wr(A_A, 0); wr(A_B, 35); wr(A_CTRL, 32'h1);
    rdchk("g0_35_stat_n1", A_STAT, 32'h11);
    rdchk("g0_35_stat_n2", A_STAT, 32'h11);
    rdchk("g0_35_res_n3", A_RES, 35);
    rdchk("g0_35_stat", A_STAT, 32'h12);
    wr(A_STAT, 32'h2);

    // gcd(0,0) = 0, still pushed
    wr(A_B, 0); wr(A_CTRL, 32'h1); idle(4);
    rdchk("g0_0_stat", A_STAT, 32'h102);
    rdchk("g0_0_res", A_RES, 0);
    rdchk("g0_0_stat_after", A_STAT, 32'h12);
    wr(A_STAT, 32'h2);

    // Full-width operands, one step: done at N+5
    wr(A_A, 32'h8000_0000); wr(A_B, 32'h4000_0000); wr(A_CTRL, 32'h1);
    for (int i = 1; i <= 5; i++)
      rdchk($sformatf("gbig_stat_n%0d", i), A_STAT, (i < 5) ? 32'h11 : 32'h102);
    rdchk("gbig_res", A_RES, 32'h4000_0000);
    wr(A_STAT, 32'h2);
    idle(1);

    // Five results into a 4-deep FIFO
    gcd_run(12, 8); gcd_run(21, 14); gcd_run(9, 6); gcd_run(10, 25); gcd_run(7, 5);
    rdchk("ovf_stat_full", A_STAT, 32'h426);
    rdchk("ovf_res0", A_RES, 4);
    rdchk("ovf_res1", A_RES, 7);
    rdchk("ovf_res2", A_RES, 3);
    rdchk("ovf_res3", A_RES, 5);
    rdchk("ovf_stat_drained", A_STAT, 32'h16);
    wr(A_STAT, 32'h4);
    rdchk("ovf_w1c", A_STAT, 32'h12);
    wr(A_STAT, 32'h2);
    rdchk("ovf_all_clear", A_STAT, 32'h10);

    // START while busy -> ERR, first result intact; IRQ level
    wr(A_A, 12); wr(A_B, 8);
    wr(A_CTRL, 32'h3); wr(A_CTRL, 32'h3); idle(20);
    rdchk("err_stat", A_STAT, 32'h10A);
    rdchk("err_ctrl_rb", A_CTRL, CTRL_RB);
    chk("err_irq", {31'd0, IRQ}, {31'd0, IRQ_ON});
    wr(A_STAT, 32'h8); idle(1);
    chk("err_irq_done_only", {31'd0, IRQ}, {31'd0, IRQ_ON});
    rdchk("err_stat_cleared", A_STAT, 32'h102);
    rdchk("err_res", A_RES, 4);
    rdchk("err_res_empty", A_RES, 0);
    wr(A_STAT, 32'h2); idle(1);
    chk("err_irq_off", {31'd0, IRQ}, 32'd0);
    wr(A_CTRL, 32'h0);

    // FLUSH, unmapped offset
    gcd_run(9, 6);
    rdchk("fl_stat_before", A_STAT, 32'h102);
    wr(A_CTRL, 32'h4);
    rdchk("fl_stat_after", A_STAT, 32'h12);
    rdchk("fl_res", A_RES, 0);
    wr(A_UNM, 32'hDEAD_BEEF);
    rdchk("unmapped_rd", A_UNM, 0);
    wr(A_STAT, 32'h2); idle(1);

    // Reset during CALC
    wr(A_A, 1000); wr(A_B, 1); wr(A_CTRL, 32'h1); idle(8);
    rdchk("rst_mid_busy", A_STAT, 32'h11);
    #3 HRESETn = 1'b0;
    idle(2);
    HRESETn = 1'b1;
    idle(1);
    rdchk("rst_mid_stat", A_STAT, 32'h10);
    rdchk("rst_mid_a", A_A, 0);

    // After reset, plus an A write landing on the LOAD cycle
    wr(A_A, 21); wr(A_B, 14); wr(A_CTRL, 32'h1); wr(A_A, 99); idle(20);
    rdchk("post_rst_res", A_RES, 7);
    rdchk("post_rst_a", A_A, 99);
    rdchk("post_rst_stat", A_STAT, 32'h12);
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
